pot_scan_sched: RTL

//  Round-robin scheduler that shares the single A2D SPI interface (ADC128S) among the six

---
 rtl/pot_scan_sched.sv | 116 +++++++++++
 1 files changed

// File: rtl/pot_scan_sched.sv
// Round-robin scan of the six slide pots through one shared A2D channel mux.
// One conversion in flight at a time; results (optionally IIR-smoothed) land in per-pot registers.
module pot_scan_sched #(
    // 3-bit A2D channel per pot index 0..5 (LP,B1,B2,B3,HP,VOL = ch 1,0,4,2,3,7)
    parameter logic [17:0] CH_MAP      = 18'o732401,
    parameter int          SETTLE_CYC  = 1024,
    parameter int          TIMEOUT_CYC = 4096,
    parameter int          FILT_SHIFT  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    output logic [11:0] POT_LP,
    output logic [11:0] POT_B1,
    output logic [11:0] POT_B2,
    output logic [11:0] POT_B3,
    output logic [11:0] POT_HP,
    output logic [11:0] VOLUME,
    output logic        scan_done,
    output logic        a2d_err
);

    typedef enum logic [1:0] {IDLE, START, WAIT, SETTLE} state_t;

    localparam int MAX_CYC = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int TW      = $clog2(MAX_CYC + 1);
    localparam logic [TW-1:0] SETTLE_LAST  = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);

    state_t        state;
    logic [2:0]    idx;
    logic [TW-1:0] timer;
    logic [5:0]    first_load;
    logic [11:0]   pot [6];

    // Step toward the new sample by diff/2^FILT_SHIFT; the arithmetic shift
    // rounds toward -inf, so the result always stays between pot and res.
    function automatic logic [11:0] smooth(input logic [11:0] cur, input logic [11:0] smp);
        logic signed [13:0] diff;
        logic signed [13:0] sum;
        diff = $signed({2'b00, smp}) - $signed({2'b00, cur});
        sum  = $signed({2'b00, cur}) + (diff >>> FILT_SHIFT);
        return sum[11:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            timer      <= '0;
            first_load <= '1;
            strt_cnv   <= 1'b0;
            chnnl      <= '0;
            scan_done  <= 1'b0;
            a2d_err    <= 1'b0;
            // NOTE: the pot registers drive outputs that must read 0 out of reset, so this small array is reset explicitly.
            for (int i = 0; i < 6; i++) pot[i] <= '0;
        end else begin
            // NOTE: pulse outputs default low every clock so each is high for exactly one cycle.
            strt_cnv  <= 1'b0;
            scan_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) state <= START;
                end
                START: begin
                    strt_cnv <= 1'b1;
                    chnnl    <= CH_MAP[3*idx +: 3];
                    timer    <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (cnv_cmplt) begin
                        pot[idx]        <= first_load[idx] ? res : smooth(pot[idx], res);
                        first_load[idx] <= 1'b0;
                        timer           <= '0;
                        state           <= SETTLE;
                    end else if (timer == TIMEOUT_LAST) begin
                        a2d_err <= 1'b1;
                        timer   <= '0;
                        state   <= SETTLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                SETTLE: begin
                    if (timer == SETTLE_LAST) begin
                        timer <= '0;
                        if (idx == 3'd5) begin
                            idx       <= '0;
                            scan_done <= 1'b1;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                        state <= en ? START : IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign POT_LP = pot[0];
    assign POT_B1 = pot[1];
    assign POT_B2 = pot[2];
    assign POT_B3 = pot[3];
    assign POT_HP = pot[4];
    assign VOLUME = pot[5];

endmodule
